// File: rtl/counter_x_pkg.sv
// Shared constants for the three-channel tick counter: widths, mode and channel codes.
package counter_x_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned NUM_CH        = 3;
  localparam int unsigned CTRL_W        = 6;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;

  localparam logic [1:0] CH0     = 2'd0;
  localparam logic [1:0] CH1     = 2'd1;
  localparam logic [1:0] CH2     = 2'd2;
  localparam logic [1:0] CH_CTRL = 2'd3;

  // Reserved mode code 11 is folded onto one-shot.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    logic [1:0] m;
    case (mode)
      MODE_PERIODIC: m = MODE_PERIODIC;
      MODE_SQUARE:   m = MODE_SQUARE;
      default:       m = MODE_ONESHOT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/counter_x_channel.sv
// One counter channel: tick synchronizer/edge detect, down-counter with reload,
// and the terminal output for one-shot, periodic and square-wave modes.
module counter_x_channel
  import counter_x_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_src,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             out
);

  logic [2:0]       sync_q;
  logic             tick_c;
  logic [1:0]       mode_c;
  logic [CNT_W-1:0] reload_q;
  logic [CNT_W-1:0] reload_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] dec_c;
  logic [CNT_W-1:0] half_c;
  logic             armed_q;
  logic             armed_d;
  logic             out_d;

  // Two-flop synchronizer followed by a history flop for rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], tick_src};
    end
  end

  assign tick_c = sync_q[1] & ~sync_q[2];
  assign mode_c = norm_mode(mode);
  assign dec_c  = count - CNT_W'(1);
  // A reload of 1 would give a zero half period; treat it as 2.
  assign half_c = (reload_q == CNT_W'(1)) ? CNT_W'(1) : (reload_q >> 1);

  always_comb begin
    count_d  = count;
    reload_d = reload_q;
    armed_d  = armed_q;
    out_d    = out;
    if (mode_c == MODE_PERIODIC) begin
      out_d = 1'b0;
    end
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      armed_d  = (load_val != '0);
      out_d    = 1'b0;
    end else if (tick_c && armed_q && (count != '0)) begin
      case (mode_c)
        MODE_PERIODIC: begin
          if (dec_c == '0) begin
            count_d = reload_q;
            out_d   = 1'b1;
          end else begin
            count_d = dec_c;
          end
        end
        MODE_SQUARE: begin
          if (dec_c == '0) begin
            count_d = half_c;
            out_d   = ~out;
          end else begin
            count_d = dec_c;
          end
        end
        default: begin
          count_d = dec_c;
          if (dec_c == '0) begin
            out_d   = 1'b1;
            armed_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      reload_q <= '0;
      armed_q  <= 1'b0;
      out      <= 1'b0;
    end else begin
      count    <= count_d;
      reload_q <= reload_d;
      armed_q  <= armed_d;
      out      <= out_d;
    end
  end

endmodule

// File: rtl/counter_x.sv
// Three-channel tick counter: write decode, control register and readback mux
// around three independent counter_x_channel instances.
module counter_x
  import counter_x_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk0,
  input  logic             clk1,
  input  logic             clk2,
  input  logic             counter_we,
  input  logic [CNT_W-1:0] counter_val,
  input  logic [1:0]       counter_ch,
  output logic             counter0_OUT,
  output logic             counter1_OUT,
  output logic             counter2_OUT,
  output logic [CNT_W-1:0] counter_out
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [NUM_CH-1:0] load_c;
  logic [NUM_CH-1:0] tick_src;
  logic [NUM_CH-1:0] out_vec;
  logic [CNT_W-1:0]  count_arr [NUM_CH];

  assign tick_src = {clk2, clk1, clk0};

  assign load_c[0] = counter_we && (counter_ch == CH0);
  assign load_c[1] = counter_we && (counter_ch == CH1);
  assign load_c[2] = counter_we && (counter_ch == CH2);

  always_comb begin
    ctrl_d = ctrl_q;
    if (counter_we && (counter_ch == CH_CTRL)) begin
      ctrl_d = counter_val[CTRL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    counter_x_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick_src(tick_src[n]),
      .mode    (ctrl_q[2*n +: 2]),
      .load    (load_c[n]),
      .load_val(counter_val),
      .count   (count_arr[n]),
      .out     (out_vec[n])
    );
  end

  assign counter0_OUT = out_vec[0];
  assign counter1_OUT = out_vec[1];
  assign counter2_OUT = out_vec[2];

  // Readback follows counter_ch combinationally.
  always_comb begin
    case (counter_ch)
      CH0:     counter_out = count_arr[0];
      CH1:     counter_out = count_arr[1];
      CH2:     counter_out = count_arr[2];
      default: counter_out = CNT_W'(ctrl_q);
    endcase
  end

endmodule

// File: tb/tb_counter_x.sv
// Directed bench for counter_x: vector table for loads/readback/independence,
// plus hand-written one-shot, periodic, square, collision and reset sequences.
module tb_counter_x;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  tsrc = 3'b000;
  logic        counter_we = 1'b0;
  logic [31:0] counter_val = '0;
  logic [1:0]  counter_ch = 2'd0;
  logic        counter0_OUT, counter1_OUT, counter2_OUT;
  logic [31:0] counter_out;

  int checks = 0;
  int errors = 0;
  int hi0;

  counter_x dut (
    .clk         (clk),
    .rst         (rst),
    .clk0        (tsrc[0]),
    .clk1        (tsrc[1]),
    .clk2        (tsrc[2]),
    .counter_we  (counter_we),
    .counter_val (counter_val),
    .counter_ch  (counter_ch),
    .counter0_OUT(counter0_OUT),
    .counter1_OUT(counter1_OUT),
    .counter2_OUT(counter2_OUT),
    .counter_out (counter_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  wch;
    logic [31:0] wval;
    logic [2:0]  tick;
    logic [1:0]  rch;
    logic [31:0] exp_rd;
    logic [2:0]  exp_outs;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tsrc = 3'b000;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [31:0] val);
    @(posedge clk); #1;
    counter_we = 1'b1;
    counter_ch = ch;
    counter_val = val;
    @(posedge clk); #1;
    counter_we = 1'b0;
  endtask

  // One 10-clk tick period on the masked sources; hi0 counts cycles with OUT0 high.
  task automatic do_tick(input logic [2:0] mask);
    @(posedge clk); #1;
    tsrc = mask;
    hi0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 4) tsrc = 3'b000;
      @(negedge clk);
      hi0 += int'(counter0_OUT);
    end
  endtask

  function automatic logic [2:0] outs();
    return {counter2_OUT, counter1_OUT, counter0_OUT};
  endfunction

  initial begin
    logic [31:0] exp_cnt;
    logic        exp_o;

    // Reset state
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      counter_ch = 2'(c);
      #1;
      check($sformatf("reset_rd%0d", c), counter_out, 32'd0);
    end
    check("reset_outs", 32'(outs()), 32'd0);

    // Loads, ticks, readback and channel independence
    vecs[0]  = '{1'b0, 2'd0, 32'd0,     3'b000, 2'd3, 32'd0, 3'b000};
    vecs[1]  = '{1'b1, 2'd0, 32'd2,     3'b000, 2'd0, 32'd2, 3'b000};
    vecs[2]  = '{1'b1, 2'd1, 32'd9,     3'b000, 2'd1, 32'd9, 3'b000};
    vecs[3]  = '{1'b1, 2'd2, 32'd0,     3'b000, 2'd2, 32'd0, 3'b000};
    vecs[4]  = '{1'b0, 2'd0, 32'd0,     3'b111, 2'd0, 32'd1, 3'b000};
    vecs[5]  = '{1'b0, 2'd0, 32'd0,     3'b111, 2'd0, 32'd0, 3'b001};
    vecs[6]  = '{1'b0, 2'd0, 32'd0,     3'b000, 2'd1, 32'd7, 3'b001};
    vecs[7]  = '{1'b0, 2'd0, 32'd0,     3'b111, 2'd2, 32'd0, 3'b001};
    vecs[8]  = '{1'b0, 2'd0, 32'd0,     3'b000, 2'd0, 32'd0, 3'b001};
    vecs[9]  = '{1'b1, 2'd3, 32'h1C4,   3'b000, 2'd3, 32'd4, 3'b001};
    vecs[10] = '{1'b0, 2'd0, 32'd0,     3'b000, 2'd1, 32'd6, 3'b001};
    vecs[11] = '{1'b0, 2'd0, 32'd0,     3'b111, 2'd1, 32'd5, 3'b001};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) do_write(vecs[i].wch, vecs[i].wval);
      if (vecs[i].tick != 3'b000) do_tick(vecs[i].tick);
      @(posedge clk); #1;
      counter_ch = vecs[i].rch;
      @(negedge clk);
      check($sformatf("vec%0d_rd", i), counter_out, vecs[i].exp_rd);
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_outs));
    end

    // One-shot: 0x10 counts down over 16 ticks, OUT0 sticks high
    do_reset();
    do_write(2'd3, 32'h00);
    do_write(2'd0, 32'h10);
    counter_ch = 2'd0;
    for (int k = 1; k <= 21; k++) begin
      do_tick(3'b001);
      exp_cnt = (k < 16) ? 32'(16 - k) : 32'd0;
      exp_o = (k >= 16);
      check($sformatf("oneshot_cnt_t%0d", k), counter_out, exp_cnt);
      check($sformatf("oneshot_out_t%0d", k), 32'(counter0_OUT), 32'(exp_o));
    end

    // Periodic: reload 3, one-cycle pulse every third tick
    do_reset();
    do_write(2'd3, 32'h01);
    do_write(2'd0, 32'd3);
    counter_ch = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      do_tick(3'b001);
      exp_cnt = ((k % 3) == 0) ? 32'd3 : 32'(3 - (k % 3));
      check($sformatf("periodic_cnt_t%0d", k), counter_out, exp_cnt);
      check($sformatf("periodic_pulse_t%0d", k), 32'(hi0), ((k % 3) == 0) ? 32'd1 : 32'd0);
    end

    // Square: reload 4, first toggle after 4 ticks then every 2
    do_reset();
    do_write(2'd3, 32'h02);
    do_write(2'd0, 32'd4);
    counter_ch = 2'd0;
    for (int k = 1; k <= 10; k++) begin
      do_tick(3'b001);
      exp_cnt = (k < 4) ? 32'(4 - k) : (((k % 2) == 0) ? 32'd2 : 32'd1);
      exp_o = (k == 4) || (k == 5) || (k == 8) || (k == 9);
      check($sformatf("square_cnt_t%0d", k), counter_out, exp_cnt);
      check($sformatf("square_out_t%0d", k), 32'(counter0_OUT), 32'(exp_o));
    end

    // Collision: write to ch1 lands in the same cycle as its tick
    do_reset();
    do_write(2'd1, 32'd5);
    do_tick(3'b010);
    @(posedge clk); #1;
    counter_ch = 2'd1;
    @(negedge clk);
    check("collide_pre", counter_out, 32'd4);
    @(posedge clk); #1;
    tsrc = 3'b010;
    @(posedge clk);
    @(posedge clk); #1;
    counter_we = 1'b1;
    counter_ch = 2'd1;
    counter_val = 32'd5;
    @(posedge clk); #1;
    counter_we = 1'b0;
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    tsrc = 3'b000;
    @(negedge clk);
    check("collide_write_wins", counter_out, 32'd5);
    do_tick(3'b010);
    check("collide_post_tick", counter_out, 32'd4);

    // Reset mid-count with a simultaneous write
    do_reset();
    do_write(2'd3, 32'h10);
    do_write(2'd0, 32'd10);
    do_write(2'd1, 32'd3);
    for (int k = 0; k < 3; k++) do_tick(3'b011);
    counter_ch = 2'd0;
    @(negedge clk);
    check("midrst_pre_cnt", counter_out, 32'd7);
    check("midrst_pre_out1", 32'(counter1_OUT), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    counter_we = 1'b1;
    counter_ch = 2'd2;
    counter_val = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0;
    counter_we = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      counter_ch = 2'(c);
      #1;
      check($sformatf("midrst_rd%0d", c), counter_out, 32'd0);
    end
    check("midrst_outs", 32'(outs()), 32'd0);
    do_tick(3'b111);
    counter_ch = 2'd0;
    #1;
    check("midrst_idle_cnt", counter_out, 32'd0);
    check("midrst_idle_outs", 32'(outs()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
